force_lut_server: RTL and testbench

Shared force look-up responder serving the LUT request port of the processing-element cores. Each PE issues a squared-distance address and waits for a 16-bit force magnitude. This block arbitrates up to NUM_PE requesters round-robin, quantizes and saturates each address to a table index, and reads a loadable synchronous table. It returns the value on the requester's response lane after a fixed 3-cycle latency.

---
 rtl/force_lut_server.sv | 144 ++++++++++++++
 tb/tb_force_lut_server.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/force_lut_server.sv
// Shared force look-up responder: round-robin arbitration over PE requesters,
// r^2 quantization/saturation to a table index, and a fixed 3-cycle table read.
module force_lut_server #(
    parameter int NUM_PE     = 4,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 16,
    parameter int IDX_W      = 8,
    parameter int ADDR_SHIFT = 4,
    parameter int R2_MIN     = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_PE-1:0]          req_valid,
    input  logic [NUM_PE*ADDR_W-1:0]   req_addr,
    output logic [NUM_PE-1:0]          req_ready,
    output logic [NUM_PE-1:0]          rsp_valid,
    output logic [NUM_PE*DATA_W-1:0]   rsp_data,
    input  logic                       tbl_wr_en,
    input  logic [IDX_W-1:0]           tbl_wr_addr,
    input  logic [DATA_W-1:0]          tbl_wr_data,
    output logic                       busy
);

    localparam int DEPTH = 2 ** IDX_W;
    localparam int ID_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = '1;

    logic [ID_W-1:0]          rr_ptr_q;
    logic [NUM_PE-1:0]        pending_q, pending_d;
    logic [NUM_PE-1:0]        eligible;
    logic                     grant_vld;
    logic [ID_W-1:0]          grant_id;
    logic [ID_W-1:0]          rr_next;

    logic [ADDR_W-1:0]        grant_addr;
    logic [ADDR_W-1:0]        shifted_addr;
    logic [IDX_W-1:0]         q_idx;
    logic                     q_zero;

    logic                     s1_valid_q, s2_valid_q, s3_valid_q;
    logic [ID_W-1:0]          s1_id_q, s2_id_q;
    logic                     s1_zero_q, s2_zero_q;
    logic [IDX_W-1:0]         s1_idx_q;
    logic [DATA_W-1:0]        rd_data_q;
    logic [NUM_PE-1:0]        rsp_valid_q;
    logic [NUM_PE*DATA_W-1:0] rsp_data_q;

    logic [DATA_W-1:0]        table_mem [DEPTH];

    // Table writes own the cycle, so no grant is issued while tbl_wr_en is high.
    always_comb begin : arbiter
        int cand;
        cand      = 0;
        eligible  = req_valid & ~pending_q;
        grant_vld = 1'b0;
        grant_id  = '0;
        req_ready = '0;
        if (!rst && !tbl_wr_en) begin
            for (int off = 0; off < NUM_PE; off++) begin
                cand = (int'(rr_ptr_q) + off) % NUM_PE;
                if (!grant_vld && eligible[cand]) begin
                    grant_vld = 1'b1;
                    grant_id  = ID_W'(cand);
                end
            end
        end
        if (grant_vld) begin
            req_ready[grant_id] = 1'b1;
        end
        rr_next = ID_W'((int'(grant_id) + 1) % NUM_PE);
    end

    // Negative r^2 means the PE's squaring overflowed, so treat it as far away.
    always_comb begin
        grant_addr   = req_addr[grant_id*ADDR_W +: ADDR_W];
        shifted_addr = grant_addr >> ADDR_SHIFT;
        q_idx        = '0;
        q_zero       = 1'b0;
        if (grant_addr[ADDR_W-1]) begin
            q_idx = IDX_MAX;
        end else if (grant_addr < ADDR_W'(R2_MIN)) begin
            q_zero = 1'b1;
        end else if (shifted_addr > ADDR_W'(DEPTH - 1)) begin
            q_idx = IDX_MAX;
        end else begin
            q_idx = shifted_addr[IDX_W-1:0];
        end
    end

    always_comb begin
        pending_d = pending_q;
        if (s2_valid_q) begin
            pending_d[s2_id_q] = 1'b0;
        end
        if (grant_vld) begin
            pending_d[grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_q    <= '0;
            pending_q   <= '0;
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            s3_valid_q  <= 1'b0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            s1_valid_q  <= grant_vld;
            s2_valid_q  <= s1_valid_q;
            s3_valid_q  <= s2_valid_q;
            pending_q   <= pending_d;
            rsp_valid_q <= '0;
            if (grant_vld) begin
                rr_ptr_q <= rr_next;
            end
            if (s2_valid_q) begin
                rsp_valid_q[s2_id_q] <= 1'b1;
                rsp_data_q[s2_id_q*DATA_W +: DATA_W] <= s2_zero_q ? '0 : rd_data_q;
            end
        end
    end

    // Payload registers and the table carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (grant_vld) begin
            s1_id_q   <= grant_id;
            s1_zero_q <= q_zero;
            s1_idx_q  <= q_idx;
        end
        s2_id_q   <= s1_id_q;
        s2_zero_q <= s1_zero_q;
        rd_data_q <= table_mem[s1_idx_q];
        if (tbl_wr_en) begin
            table_mem[tbl_wr_addr] <= tbl_wr_data;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = s1_valid_q | s2_valid_q | s3_valid_q;

endmodule

// File: tb/tb_force_lut_server.sv
// Scoreboard bench for force_lut_server: accepts push expected responses,
// the negedge monitor pops and checks lane, data and exact cycle.
module tb_force_lut_server;

    localparam int NUM_PE = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 16;
    localparam int IDX_W  = 8;
    localparam int R2_MIN = 1;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_PE-1:0]        req_valid;
    logic [NUM_PE*ADDR_W-1:0] req_addr;
    logic [NUM_PE-1:0]        req_ready;
    logic [NUM_PE-1:0]        rsp_valid;
    logic [NUM_PE*DATA_W-1:0] rsp_data;
    logic                     tbl_wr_en;
    logic [IDX_W-1:0]         tbl_wr_addr;
    logic [DATA_W-1:0]        tbl_wr_data;
    logic                     busy;

    typedef struct {
        int          pe;
        logic [15:0] data;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [15:0] tbl_model [256];
    int          checks   = 0;
    int          failures = 0;
    int          cycle    = 0;
    bit          mon_en   = 1'b0;
    logic [3:0]  last_acc = '0;
    logic        exp_busy;

    force_lut_server #(
        .NUM_PE(NUM_PE), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
        .IDX_W(IDX_W), .ADDR_SHIFT(4), .R2_MIN(R2_MIN)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .tbl_wr_en(tbl_wr_en), .tbl_wr_addr(tbl_wr_addr), .tbl_wr_data(tbl_wr_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [15:0] model_value(input logic [31:0] a);
        logic [31:0] q;
        if (a[31]) return tbl_model[255];
        if (a < 32'(R2_MIN)) return 16'h0000;
        q = a >> 4;
        if (q > 32'd255) return tbl_model[255];
        return tbl_model[q[7:0]];
    endfunction

    // Monitor: busy model, response scoreboard, grant sanity, then record accepts.
    always @(negedge clk) begin
        if (mon_en) begin
            exp_busy = 1'b0;
            foreach (sb[i]) if (sb[i].due >= cycle && sb[i].due <= cycle + 2) exp_busy = 1'b1;
            checks++;
            if (busy !== exp_busy) begin
                failures++;
                $display("[TB] FAIL busy cycle %0d: got %b expected %b", cycle, busy, exp_busy);
            end
            if (rsp_valid !== '0) begin
                if (sb.size() == 0) begin
                    checks++; failures++;
                    $display("[TB] FAIL unexpected_rsp cycle %0d: got rsp_valid=%b expected 0000", cycle, rsp_valid);
                end else begin
                    e = sb.pop_front();
                    checks++;
                    if (rsp_valid !== (4'b0001 << e.pe) || cycle != e.due ||
                        rsp_data[e.pe*16 +: 16] !== e.data) begin
                        failures++;
                        $display("[TB] FAIL response cycle %0d: got valid=%b data=%h expected valid=%b data=%h at cycle %0d",
                                 cycle, rsp_valid, rsp_data[e.pe*16 +: 16], 4'b0001 << e.pe, e.data, e.due);
                    end
                end
            end else if (sb.size() > 0 && sb[0].due <= cycle) begin
                e = sb.pop_front();
                checks++; failures++;
                $display("[TB] FAIL missing_rsp cycle %0d: got rsp_valid=0000 expected PE%0d data=%h", cycle, e.pe, e.data);
            end
            checks++;
            if ($countones(req_ready) > 1 || (tbl_wr_en === 1'b1 && req_ready !== '0) ||
                (rst === 1'b1 && req_ready !== '0)) begin
                failures++;
                $display("[TB] FAIL grant_rule cycle %0d: got req_ready=%b expected one-hot, zero on write/reset", cycle, req_ready);
            end
            if (rst === 1'b1) sb.delete();
        end
        last_acc = req_valid & req_ready;
        if (mon_en) begin
            for (int i = 0; i < NUM_PE; i++) begin
                if (last_acc[i]) sb.push_back('{pe: i, data: model_value(req_addr[i*32 +: 32]), due: cycle + 3});
            end
        end
        if (tbl_wr_en === 1'b1) tbl_model[tbl_wr_addr] = tbl_wr_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
        req_valid = req_valid & ~last_acc;
    endtask

    task automatic write_table(input logic [7:0] idx, input logic [15:0] data);
        tbl_wr_en   = 1'b1;
        tbl_wr_addr = idx;
        tbl_wr_data = data;
        tick();
        tbl_wr_en   = 1'b0;
    endtask

    task automatic issue(input int pe, input logic [31:0] addr);
        bit got = 1'b0;
        req_valid[pe] = 1'b1;
        req_addr[pe*32 +: 32] = addr;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (req_ready[pe] === 1'b1) got = 1'b1;
            tick();
        end
        checks++;
        if (!got) begin
            failures++;
            $display("[TB] FAIL grant_timeout PE%0d: got no grant expected grant within 20 cycles", pe);
        end
        req_valid[pe] = 1'b0;
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int n = 0; n < 40 && !done; n++) begin
            @(negedge clk);
            if (sb.size() == 0 && busy === 1'b0) done = 1'b1;
            tick();
        end
        checks++;
        if (!done) begin
            failures++;
            $display("[TB] FAIL drain: got %0d outstanding expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = '1; req_addr = '0;
        tbl_wr_en = 1'b0; tbl_wr_addr = '0; tbl_wr_data = '0;
        tick(); tick();
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_data !== '0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_state: got ready=%b valid=%b data=%h busy=%b expected all zero",
                     req_ready, rsp_valid, rsp_data, busy);
        end
        tick();
        req_valid = '0;
        rst = 1'b0;
        mon_en = 1'b1;
        tick();
    endtask

    task automatic test_single();
        write_table(8'd4, 16'h1234);
        req_valid[0] = 1'b1;
        req_addr[31:0] = 32'h40;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL single_grant: got %b expected 0001", req_ready);
        end
        for (int k = 1; k <= 4; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if (busy !== (k <= 3)) begin
                failures++;
                $display("[TB] FAIL single_busy T+%0d: got %b expected %b", k, busy, (k <= 3));
            end
            if (k == 3) begin
                checks++;
                if (rsp_valid !== 4'b0001 || rsp_data[15:0] !== 16'h1234) begin
                    failures++;
                    $display("[TB] FAIL single_rsp: got valid=%b data=%h expected 0001 1234", rsp_valid, rsp_data[15:0]);
                end
            end
        end
        tick();
    endtask

    task automatic test_saturation();
        write_table(8'd255, 16'h0007);
        issue(1, 32'h000F_FFF0);
        issue(1, 32'h8000_0000);
        issue(1, 32'h0000_0FF0);
        drain();
    endtask

    task automatic test_cutoff();
        write_table(8'd0, 16'h7FFF);
        issue(2, 32'h0);
        issue(2, 32'h1);
        drain();
    endtask

    task automatic test_write_stall();
        tbl_wr_en = 1'b1; tbl_wr_addr = 8'h22; tbl_wr_data = 16'h5A5A;
        req_valid[3] = 1'b1;
        req_addr[3*32 +: 32] = 32'h220;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("[TB] FAIL stall_write_cycle: got %b expected 0000", req_ready);
        end
        tick();
        tbl_wr_en = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            failures++;
            $display("[TB] FAIL stall_next_cycle: got %b expected 1000", req_ready);
        end
        tick();
        drain();
    endtask

    task automatic test_reset_midflight();
        req_valid[0] = 1'b1;
        req_addr[31:0] = 32'h40;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("[TB] FAIL midflight_grant: got %b expected 0001", req_ready);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== '0 || rsp_valid !== '0 || rsp_data !== '0 || busy !== 1'b0) begin
            failures++;
            $display("[TB] FAIL midflight_cleared: got ready=%b valid=%b data=%h busy=%b expected all zero",
                     req_ready, rsp_valid, rsp_data, busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (rsp_valid !== '0) begin
            failures++;
            $display("[TB] FAIL midflight_no_rsp: got %b expected 0000", rsp_valid);
        end
        tick();
        req_valid[2] = 1'b1;
        req_addr[2*32 +: 32] = 32'h40;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("[TB] FAIL post_reset_grant: got %b expected 0100", req_ready);
        end
        tick();
        drain();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt [6];
        exp_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
        write_table(8'd1, 16'h1111);
        write_table(8'd2, 16'h2222);
        write_table(8'd3, 16'h3333);
        write_table(8'd5, 16'h5555);
        write_table(8'd6, 16'h6666);
        write_table(8'd7, 16'h7777);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        req_addr = {32'h50, 32'h30, 32'h20, 32'h10};
        req_valid = 4'b1111;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== exp_gnt[k]) begin
                failures++;
                $display("[TB] FAIL rr_grant step %0d: got %b expected %b", k, req_ready, exp_gnt[k]);
            end
            tick();
            if (k == 0) begin
                req_valid[0] = 1'b1;
                req_addr[31:0] = 32'h60;
            end
            if (k == 1) begin
                req_valid[1] = 1'b1;
                req_addr[63:32] = 32'h70;
            end
        end
        drain();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_saturation();
        test_cutoff();
        test_write_stall();
        test_reset_midflight();
        test_round_robin();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
